up_gpio_bank: RTL and testbench

//  Parametrised GPIO bank: per-bit direction/output regs, input sync, debounce, edge IRQ.

---
 rtl/up_gpio_pkg.sv | 13 +
 rtl/gpio_debounce.sv | 61 ++++++
 rtl/up_gpio_bank.sv | 158 +++++++++++++++
 tb/tb_up_gpio_bank.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/up_gpio_pkg.sv
// Register map shared by the GPIO bank and anything that drives its up bus.
package up_gpio_pkg;

    localparam logic [2:0] ADDR_DATA_OUT     = 3'd0;
    localparam logic [2:0] ADDR_DIR          = 3'd1;
    localparam logic [2:0] ADDR_DATA_IN      = 3'd2;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN      = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN      = 3'd5;
    localparam logic [2:0] ADDR_IRQ_STATUS   = 3'd6;
    localparam logic [2:0] ADDR_DEBOUNCE_DIV = 3'd7;

endpackage

// File: rtl/gpio_debounce.sv
// Prescaled per-bit debouncer: a bit follows its input only after DEBOUNCE_SAMPLES
// consecutive ticks disagree with it. div == 0 passes the input straight through.
module gpio_debounce #(
    parameter int unsigned NUM_GPIO         = 32,
    parameter int unsigned DEBOUNCE_SAMPLES = 4,
    parameter int unsigned DIV_WIDTH        = 16
) (
    input  logic                 aclk,
    input  logic                 arst,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 div_clr,
    input  logic [NUM_GPIO-1:0]  din,
    output logic [NUM_GPIO-1:0]  dout
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SAMPLES - 1);

    logic [DIV_WIDTH-1:0] r_pre;
    logic [CNT_W-1:0]     r_cnt [NUM_GPIO];
    logic [NUM_GPIO-1:0]  r_dout;
    logic                 w_bypass;
    logic                 w_tick;

    assign w_bypass = (div == '0);
    assign w_tick   = !w_bypass && (r_pre == div);
    assign dout     = r_dout;

    always_ff @(posedge aclk) begin
        if (arst || div_clr || w_bypass || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_dout <= '0;
            for (int i = 0; i < NUM_GPIO; i++) r_cnt[i] <= '0;
        end else if (w_bypass) begin
            r_dout <= din;
            for (int i = 0; i < NUM_GPIO; i++) r_cnt[i] <= '0;
        end else if (div_clr) begin
            for (int i = 0; i < NUM_GPIO; i++) r_cnt[i] <= '0;
        end else if (w_tick) begin
            for (int i = 0; i < NUM_GPIO; i++) begin
                if (din[i] == r_dout[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    // This tick is the last of DEBOUNCE_SAMPLES disagreeing ones.
                    r_dout[i] <= din[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/up_gpio_bank.sv
// GPIO bank on the up register bus: direction/output registers, synchronised and
// debounced inputs, masked rise/fall edge interrupt with W1C status.
module up_gpio_bank
    import up_gpio_pkg::*;
#(
    parameter int unsigned         NUM_GPIO         = 32,
    parameter int unsigned         SYNC_STAGES      = 2,
    parameter int unsigned         DEBOUNCE_SAMPLES = 4,
    parameter int unsigned         DIV_WIDTH        = 16,
    parameter logic [NUM_GPIO-1:0] RESET_DIR        = '0
) (
    input  logic                aclk,
    input  logic                arst,
    input  logic                up_wreq,
    input  logic [2:0]          up_waddr,
    input  logic [31:0]         up_wdata,
    output logic                up_wack,
    input  logic                up_rreq,
    input  logic [2:0]          up_raddr,
    output logic [31:0]         up_rdata,
    output logic                up_rack,
    input  logic [NUM_GPIO-1:0] gpio_i,
    output logic [NUM_GPIO-1:0] gpio_o,
    output logic [NUM_GPIO-1:0] gpio_t,
    output logic                irq
);

    localparam int unsigned ARM_CYC = SYNC_STAGES + 2;
    localparam int unsigned ARM_W   = $clog2(ARM_CYC + 1);

    logic [NUM_GPIO-1:0]  r_data_out, r_dir, r_irq_mask, r_rise_en, r_fall_en, r_status;
    logic [DIV_WIDTH-1:0] r_div;
    logic [NUM_GPIO-1:0]  r_gpio_o, r_gpio_t, r_deb_d;
    logic [NUM_GPIO-1:0]  r_sync [SYNC_STAGES];
    logic [ARM_W-1:0]     r_arm_cnt;
    logic                 r_wack, r_rack, r_irq;
    logic [31:0]          r_rdata;

    logic [NUM_GPIO-1:0]  w_deb, w_rise, w_fall, w_set, w_clr;
    logic [31:0]          w_rdata;
    logic                 w_armed, w_div_clr;
    logic                 w_unused_wdata;

    assign w_unused_wdata = ^up_wdata;
    assign w_div_clr      = up_wreq && (up_waddr == ADDR_DEBOUNCE_DIV);

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_data_out <= '0;
            r_dir      <= RESET_DIR;
            r_irq_mask <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
            r_div      <= '0;
            r_wack     <= 1'b0;
        end else begin
            r_wack <= up_wreq;
            if (up_wreq) begin
                case (up_waddr)
                    ADDR_DATA_OUT:     r_data_out <= up_wdata[NUM_GPIO-1:0];
                    ADDR_DIR:          r_dir      <= up_wdata[NUM_GPIO-1:0];
                    ADDR_IRQ_MASK:     r_irq_mask <= up_wdata[NUM_GPIO-1:0];
                    ADDR_RISE_EN:      r_rise_en  <= up_wdata[NUM_GPIO-1:0];
                    ADDR_FALL_EN:      r_fall_en  <= up_wdata[NUM_GPIO-1:0];
                    ADDR_DEBOUNCE_DIV: r_div      <= up_wdata[DIV_WIDTH-1:0];
                    default:           ;
                endcase
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (up_raddr)
            ADDR_DATA_OUT:     w_rdata[NUM_GPIO-1:0]  = r_data_out;
            ADDR_DIR:          w_rdata[NUM_GPIO-1:0]  = r_dir;
            ADDR_DATA_IN:      w_rdata[NUM_GPIO-1:0]  = w_deb;
            ADDR_IRQ_MASK:     w_rdata[NUM_GPIO-1:0]  = r_irq_mask;
            ADDR_RISE_EN:      w_rdata[NUM_GPIO-1:0]  = r_rise_en;
            ADDR_FALL_EN:      w_rdata[NUM_GPIO-1:0]  = r_fall_en;
            ADDR_IRQ_STATUS:   w_rdata[NUM_GPIO-1:0]  = r_status;
            ADDR_DEBOUNCE_DIV: w_rdata[DIV_WIDTH-1:0] = r_div;
            default:           w_rdata = '0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_rack  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_rack <= up_rreq;
            if (up_rreq) r_rdata <= w_rdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_gpio_o <= '0;
            r_gpio_t <= ~RESET_DIR;
        end else begin
            r_gpio_o <= r_data_out;
            r_gpio_t <= ~r_dir;
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= gpio_i;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    gpio_debounce #(
        .NUM_GPIO         (NUM_GPIO),
        .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES),
        .DIV_WIDTH        (DIV_WIDTH)
    ) u_debounce (
        .aclk    (aclk),
        .arst    (arst),
        .div     (r_div),
        .div_clr (w_div_clr),
        .din     (r_sync[SYNC_STAGES-1]),
        .dout    (w_deb)
    );

    // Inputs already high at reset release ripple through sync/debounce; hold off
    // edge detection until that settles so they are not mistaken for rising edges.
    assign w_armed = (r_arm_cnt == ARM_W'(ARM_CYC));
    assign w_rise  = w_deb & ~r_deb_d;
    assign w_fall  = ~w_deb & r_deb_d;
    assign w_set   = w_armed ? ((w_rise & r_rise_en) | (w_fall & r_fall_en)) : '0;
    assign w_clr   = (up_wreq && (up_waddr == ADDR_IRQ_STATUS)) ? up_wdata[NUM_GPIO-1:0] : '0;

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_arm_cnt <= '0;
            r_deb_d   <= '0;
            r_status  <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (!w_armed) r_arm_cnt <= r_arm_cnt + ARM_W'(1);
            r_deb_d  <= w_deb;
            r_status <= (r_status & ~w_clr) | w_set;
            r_irq    <= |(r_status & r_irq_mask);
        end
    end

    assign up_wack  = r_wack;
    assign up_rack  = r_rack;
    assign up_rdata = r_rdata;
    assign gpio_o   = r_gpio_o;
    assign gpio_t   = r_gpio_t;
    assign irq      = r_irq;

endmodule

// File: tb/tb_up_gpio_bank.sv
// Directed bench for up_gpio_bank; read data and write acks are checked by a monitor
// against expectation queues filled when each transaction is issued.
module tb_up_gpio_bank;
    import up_gpio_pkg::*;

    logic        aclk = 1'b0;
    logic        arst = 1'b1;
    logic        up_wreq = 1'b0;
    logic [2:0]  up_waddr = '0;
    logic [31:0] up_wdata = '0;
    logic        up_wack;
    logic        up_rreq = 1'b0;
    logic [2:0]  up_raddr = '0;
    logic [31:0] up_rdata;
    logic        up_rack;
    logic [31:0] gpio_i = '1;
    logic [31:0] gpio_o;
    logic [31:0] gpio_t;
    logic        irq;

    typedef struct {
        string       name;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t rq[$];
    int      wq[$];
    int      n_cmp = 0;
    int      n_err = 0;

    up_gpio_bank #(
        .NUM_GPIO         (32),
        .SYNC_STAGES      (2),
        .DEBOUNCE_SAMPLES (4),
        .DIV_WIDTH        (16),
        .RESET_DIR        (32'h0)
    ) dut (
        .aclk     (aclk),
        .arst     (arst),
        .up_wreq  (up_wreq),
        .up_waddr (up_waddr),
        .up_wdata (up_wdata),
        .up_wack  (up_wack),
        .up_rreq  (up_rreq),
        .up_raddr (up_raddr),
        .up_rdata (up_rdata),
        .up_rack  (up_rack),
        .gpio_i   (gpio_i),
        .gpio_o   (gpio_o),
        .gpio_t   (gpio_t),
        .irq      (irq)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge aclk) begin : monitor
        rd_exp_t e;
        if (up_rack === 1'b1) begin
            if (rq.size() == 0) begin
                chk("unexpected_rack", 32'd1, 32'd0);
            end else begin
                e = rq.pop_front();
                chk(e.name, up_rdata, e.data);
            end
        end
        if (up_wack === 1'b1) begin
            if (wq.size() == 0) chk("unexpected_wack", 32'd1, 32'd0);
            else void'(wq.pop_front());
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(posedge aclk); #1;
        wq.push_back(1);
        up_wreq = 1'b1; up_waddr = a; up_wdata = d;
        @(posedge aclk); #1;
        up_wreq = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
        rd_exp_t e;
        @(posedge aclk); #1;
        e.name = name; e.data = exp;
        rq.push_back(e);
        up_rreq = 1'b1; up_raddr = a;
        @(posedge aclk); #1;
        up_rreq = 1'b0;
    endtask

    task automatic bus_rw(input logic [2:0] wa, input logic [31:0] wd,
                          input logic [2:0] ra, input logic [31:0] exp, input string name);
        rd_exp_t e;
        @(posedge aclk); #1;
        e.name = name; e.data = exp;
        rq.push_back(e);
        wq.push_back(1);
        up_wreq = 1'b1; up_waddr = wa; up_wdata = wd;
        up_rreq = 1'b1; up_raddr = ra;
        @(posedge aclk); #1;
        up_wreq = 1'b0; up_rreq = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Inputs high through reset release, with all edge enables armed right away.
        repeat (3) @(posedge aclk);
        #1 arst = 1'b0;
        bus_write(ADDR_RISE_EN, 32'hFFFF_FFFF);
        bus_write(ADDR_IRQ_MASK, 32'hFFFF_FFFF);
        repeat (8) @(posedge aclk);
        #1;
        chk("post_reset_irq", irq, 32'd0);
        chk("reset_gpio_t", gpio_t, 32'hFFFF_FFFF);
        chk("reset_gpio_o", gpio_o, 32'h0);
        bus_read(ADDR_IRQ_STATUS, 32'h0, "post_reset_status");
        bus_read(ADDR_DATA_IN, 32'hFFFF_FFFF, "data_in_all_ones");
        bus_read(ADDR_DIR, 32'h0, "reset_dir");
        bus_write(ADDR_RISE_EN, 32'h0);
        bus_write(ADDR_IRQ_MASK, 32'h0);
        gpio_i = '0;
        repeat (6) @(posedge aclk);
        bus_read(ADDR_DATA_IN, 32'h0, "data_in_all_zero");

        // Direction and output registers reach the pads one cycle after the write.
        bus_write(ADDR_DIR, 32'hF);
        chk("gpio_t_before", gpio_t, 32'hFFFF_FFFF);
        @(posedge aclk); #1;
        chk("gpio_t_after", gpio_t, 32'hFFFF_FFF0);
        bus_write(ADDR_DATA_OUT, 32'hA);
        chk("gpio_o_before", gpio_o, 32'h0);
        @(posedge aclk); #1;
        chk("gpio_o_after", gpio_o, 32'hA);
        bus_read(ADDR_DATA_OUT, 32'hA, "rd_data_out");
        bus_read(ADDR_DIR, 32'hF, "rd_dir");

        // Rising edge on pin 5 with bypassed debounce.
        bus_write(ADDR_RISE_EN, 32'h20);
        bus_write(ADDR_IRQ_MASK, 32'h20);
        @(posedge aclk); #1;
        gpio_i[5] = 1'b1;
        repeat (4) @(posedge aclk);
        #1;
        chk("irq_at_status_edge", irq, 32'd0);
        @(posedge aclk); #1;
        chk("irq_rise5", irq, 32'd1);
        bus_read(ADDR_IRQ_STATUS, 32'h20, "status_rise5");
        bus_write(ADDR_IRQ_STATUS, 32'h20);
        chk("irq_hold_after_w1c", irq, 32'd1);
        @(posedge aclk); #1;
        chk("irq_cleared", irq, 32'd0);
        bus_read(ADDR_IRQ_STATUS, 32'h0, "status_w1c");

        // Falling edge on pin 2 coinciding with a W1C of bit 2: set wins.
        bus_write(ADDR_FALL_EN, 32'h4);
        gpio_i[2] = 1'b1;
        repeat (6) @(posedge aclk);
        @(posedge aclk); #1;
        gpio_i[2] = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        bus_write(ADDR_IRQ_STATUS, 32'h4);
        bus_read(ADDR_IRQ_STATUS, 32'h4, "status_set_wins");
        chk("irq_unmasked_bit", irq, 32'd0);
        bus_write(ADDR_IRQ_STATUS, 32'h4);
        bus_read(ADDR_IRQ_STATUS, 32'h0, "status_bit2_cleared");

        // Debounce: DIV=3 gives a tick every 4 cycles, 4 ticks to change.
        bus_write(ADDR_DEBOUNCE_DIV, 32'h0001_2345);
        bus_read(ADDR_DEBOUNCE_DIV, 32'h0000_2345, "div_width_mask");
        bus_write(ADDR_DEBOUNCE_DIV, 32'h3);
        bus_read(ADDR_DEBOUNCE_DIV, 32'h3, "div_readback");
        @(posedge aclk); #1;
        gpio_i[0] = 1'b1;
        repeat (8) @(posedge aclk);
        #1 gpio_i[0] = 1'b0;
        repeat (20) @(posedge aclk);
        bus_read(ADDR_DATA_IN, 32'h20, "glitch_filtered");
        @(posedge aclk); #1;
        gpio_i[0] = 1'b1;
        repeat (5) @(posedge aclk);
        #1;
        bus_read(ADDR_DATA_IN, 32'h20, "debounce_not_yet");
        repeat (20) @(posedge aclk);
        bus_read(ADDR_DATA_IN, 32'h21, "debounce_settled");

        // Simultaneous read and write of the same register returns the old value.
        bus_rw(ADDR_DATA_OUT, 32'h55, ADDR_DATA_OUT, 32'hA, "rw_pre_write");
        bus_read(ADDR_DATA_OUT, 32'h55, "rw_post_write");

        // Reset mid-operation, with a write in flight that must be dropped.
        @(posedge aclk); #1;
        arst = 1'b1;
        up_wreq = 1'b1; up_waddr = ADDR_DIR; up_wdata = 32'hFF;
        @(posedge aclk); #1;
        arst = 1'b0;
        up_wreq = 1'b0;
        chk("midreset_gpio_t", gpio_t, 32'hFFFF_FFFF);
        chk("midreset_gpio_o", gpio_o, 32'h0);
        chk("midreset_irq", irq, 32'd0);
        bus_read(ADDR_DIR, 32'h0, "midreset_dir");
        bus_read(ADDR_DEBOUNCE_DIV, 32'h0, "midreset_div");
        bus_read(ADDR_DATA_OUT, 32'h0, "midreset_data_out");
        repeat (6) @(posedge aclk);
        bus_read(ADDR_IRQ_STATUS, 32'h0, "midreset_status");

        repeat (4) @(posedge aclk);
        #1;
        chk("read_queue_drained", rq.size(), 32'd0);
        chk("wack_queue_drained", wq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
